// File: rtl/iq_power_avg_pkg.sv
// Shared widths, stage-valid bundle and saturating resize for the IQ power averaging path.
package iq_power_pkg;

    localparam int unsigned IW_DEF       = 16;
    localparam int unsigned AVG_LOG2_DEF = 4;
    localparam int unsigned OW_DEF       = 32;
    localparam int unsigned SQ_W         = 2 * IW_DEF;
    localparam int unsigned ACC_W        = SQ_W + AVG_LOG2_DEF;

    typedef struct packed {
        logic s1;
        logic s2;
        logic s3;
    } stage_vld_t;

    // Clamp an unsigned value to the largest number representable on ow bits.
    function automatic logic [63:0] sat_resize(input logic [63:0] val, input int unsigned ow);
        logic [63:0] lim;
        if (ow >= 64) begin
            return val;
        end
        lim = (64'd1 << ow) - 64'd1;
        return (val > lim) ? lim : val;
    endfunction

endpackage

// File: rtl/iq_power_avg_if.sv
// Sample-in / power-out stream bundle; m_peak exists only with IQ_POWER_PEAK_EN.
interface iq_power_avg_if
    import iq_power_pkg::*;
#(
    parameter int unsigned IW = IW_DEF,
    parameter int unsigned OW = OW_DEF
);
    logic signed [IW-1:0] s_i;
    logic signed [IW-1:0] s_q;
    logic                 s_valid;
    logic                 s_ready;
    logic [OW-1:0]        m_pow;
    logic                 m_valid;
    logic                 m_ready;
`ifdef IQ_POWER_PEAK_EN
    logic [OW-1:0]        m_peak;

    modport master (output s_i, s_q, s_valid, m_ready,
                    input  s_ready, m_pow, m_valid, m_peak);
    modport slave  (input  s_i, s_q, s_valid, m_ready,
                    output s_ready, m_pow, m_valid, m_peak);
`else
    modport master (output s_i, s_q, s_valid, m_ready,
                    input  s_ready, m_pow, m_valid);
    modport slave  (input  s_i, s_q, s_valid, m_ready,
                    output s_ready, m_pow, m_valid);
`endif
endinterface

// File: rtl/iq_mag_sq.sv
// Three-stage I^2+Q^2 pipeline with stall enable and flush; reusable by other magnitude paths.
module iq_mag_sq
    import iq_power_pkg::*;
#(
    parameter int unsigned IW  = IW_DEF,
    parameter int unsigned SqW = SQ_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr_i,
    input  logic                 en_i,
    input  logic                 vld_i,
    input  logic signed [IW-1:0] i_i,
    input  logic signed [IW-1:0] q_i,
    output logic [SqW-1:0]       sq_o,
    output logic                 vld_o
);
    stage_vld_t            vld_q, vld_d;
    logic signed [IW-1:0]  i1_q, q1_q;
    logic signed [SqW-1:0] i1_x, q1_x, ii_s, qq_s;
    logic [SqW-1:0]        ii_q, qq_q, sq_q;

    assign i1_x = SqW'(i1_q);
    assign q1_x = SqW'(q1_q);
    assign ii_s = i1_x * i1_x;
    assign qq_s = q1_x * q1_x;

    always_comb begin
        vld_d = vld_q;
        if (clr_i) begin
            vld_d = '0;
        end else if (en_i) begin
            vld_d.s1 = vld_i;
            vld_d.s2 = vld_q.s1;
            vld_d.s3 = vld_q.s2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            i1_q  <= '0;
            q1_q  <= '0;
            ii_q  <= '0;
            qq_q  <= '0;
            sq_q  <= '0;
        end else begin
            vld_q <= vld_d;
            if (en_i) begin
                i1_q <= i_i;
                q1_q <= q_i;
                ii_q <= $unsigned(ii_s);
                qq_q <= $unsigned(qq_s);
                // Sum of two squares peaks at 2^(SqW-1), so it never wraps.
                sq_q <= ii_q + qq_q;
            end
        end
    end

    assign sq_o  = sq_q;
    assign vld_o = vld_q.s3;
endmodule

// File: rtl/iq_power_avg.sv
// Block-mean of I^2+Q^2 over 2^AVG_LOG2 samples, feeding the square-root stage.
// Optional per-block peak output enabled by defining IQ_POWER_PEAK_EN.
module iq_power_avg
    import iq_power_pkg::*;
#(
    parameter int unsigned IW       = IW_DEF,
    parameter int unsigned AVG_LOG2 = AVG_LOG2_DEF,
    parameter int unsigned OW       = OW_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    iq_power_avg_if.slave bus
);
    localparam int unsigned SqW  = 2 * IW;
    localparam int unsigned AccW = SqW + AVG_LOG2;
    localparam int unsigned CntW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [CntW-1:0] CntMax = CntW'((1 << AVG_LOG2) - 1);

    logic            stall, en, accept, take, close;
    logic [SqW-1:0]  sq, mean;
    logic            sq_vld;
    logic [AccW-1:0] acc_q, acc_d, acc_sum;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [OW-1:0]   pow_q, pow_d;
    logic            m_valid_q, m_valid_d;

    assign stall       = m_valid_q && !bus.m_ready;
    assign en          = !stall;
    assign bus.s_ready = en;
    assign accept      = bus.s_valid && en && !clr;

    iq_mag_sq #(
        .IW  (IW),
        .SqW (SqW)
    ) u_mag_sq (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (clr),
        .en_i  (en),
        .vld_i (accept),
        .i_i   (bus.s_i),
        .q_i   (bus.s_q),
        .sq_o  (sq),
        .vld_o (sq_vld)
    );

    assign take  = sq_vld && en && !clr;
    assign close = take && (cnt_q == CntMax);

    always_comb begin
        acc_sum   = ((cnt_q == '0) ? '0 : acc_q) + AccW'(sq);
        mean      = SqW'(acc_sum >> AVG_LOG2);
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        pow_d     = pow_q;
        m_valid_d = m_valid_q;
        if (clr) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (take) begin
            acc_d = acc_sum;
            cnt_d = (cnt_q == CntMax) ? '0 : cnt_q + 1'b1;
        end
        if (close) begin
            m_valid_d = 1'b1;
            pow_d     = OW'(sat_resize(64'(mean), OW));
        end else if (m_valid_q && bus.m_ready) begin
            m_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q     <= '0;
            cnt_q     <= '0;
            pow_q     <= '0;
            m_valid_q <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            pow_q     <= pow_d;
            m_valid_q <= m_valid_d;
        end
    end

    assign bus.m_pow   = pow_q;
    assign bus.m_valid = m_valid_q;

`ifdef IQ_POWER_PEAK_EN
    logic [SqW-1:0] peak_q, peak_d;
    logic [OW-1:0]  m_peak_q, m_peak_d;

    always_comb begin
        peak_d   = peak_q;
        m_peak_d = m_peak_q;
        if (clr) begin
            peak_d = '0;
        end else if (take) begin
            peak_d = ((cnt_q == '0) || (sq > peak_q)) ? sq : peak_q;
        end
        if (close) begin
            m_peak_d = OW'(sat_resize(64'(peak_d), OW));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            peak_q   <= '0;
            m_peak_q <= '0;
        end else begin
            peak_q   <= peak_d;
            m_peak_q <= m_peak_d;
        end
    end

    assign bus.m_peak = m_peak_q;
`endif
endmodule

// File: tb/tb_iq_power_avg.sv
// Directed bench for iq_power_avg with a block-mean reference model and literal anchors.
module tb_iq_power_avg;
    localparam int unsigned IW       = 16;
    localparam int unsigned AVG_LOG2 = 2;
    localparam int unsigned OW       = 32;
    localparam int          Blk      = 1 << AVG_LOG2;

    logic clk = 1'b0;
    logic rst_n;
    logic clr;

    always #5 clk = ~clk;

    iq_power_avg_if #(.IW(IW), .OW(OW)) ifc ();

    iq_power_avg #(
        .IW       (IW),
        .AVG_LOG2 (AVG_LOG2),
        .OW       (OW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .bus   (ifc)
    );

    int checks   = 0;
    int failures = 0;

    longint part[$];
    longint exp_pow[$];
    longint exp_pk[$];

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // Reference model: every Blk accepted samples form one expected mean (and peak).
    always @(negedge clk) begin : model
        longint iv, qv, sum, pk;
        if (!rst_n) begin
            part.delete();
            exp_pow.delete();
            exp_pk.delete();
        end else begin
            check("s_ready_rule", longint'(ifc.s_ready),
                  longint'(!(ifc.m_valid && !ifc.m_ready)));
            if (ifc.m_valid && ifc.m_ready) begin
                if (exp_pow.size() == 0) begin
                    check("unexpected_output", 1, 0);
                end else begin
                    check("model_pow", longint'(ifc.m_pow), exp_pow.pop_front());
`ifdef IQ_POWER_PEAK_EN
                    check("model_peak", longint'(ifc.m_peak), exp_pk.pop_front());
`else
                    void'(exp_pk.pop_front());
`endif
                end
            end
            if (clr) begin
                part.delete();
            end else if (ifc.s_valid && ifc.s_ready) begin
                iv = longint'(ifc.s_i);
                qv = longint'(ifc.s_q);
                part.push_back(iv * iv + qv * qv);
                if (part.size() == Blk) begin
                    sum = 0;
                    pk  = 0;
                    foreach (part[k]) begin
                        sum += part[k];
                        if (part[k] > pk) pk = part[k];
                    end
                    exp_pow.push_back(sum >> AVG_LOG2);
                    exp_pk.push_back(pk);
                    part.delete();
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int i, input int q);
        bit ok;
        int n;
        n = 0;
        ifc.s_i     = IW'(i);
        ifc.s_q     = IW'(q);
        ifc.s_valid = 1'b1;
        do begin
            @(negedge clk);
            ok = ifc.s_ready;
            tick();
            n++;
        end while (!ok && n < 200);
        if (!ok) check("send_timeout", 0, 1);
        ifc.s_valid = 1'b0;
    endtask

    // Returns at a falling edge where m_valid is expected high.
    task automatic wait_valid(input string name, input longint req);
        int n;
        n = 0;
        @(negedge clk);
        while (!ifc.m_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({name, "_valid"}, longint'(ifc.m_valid), 1);
        check(name, longint'(ifc.m_pow), req);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n       = 1'b0;
        clr         = 1'b0;
        ifc.s_valid = 1'b0;
        ifc.s_i     = '0;
        ifc.s_q     = '0;
        ifc.m_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_s_ready", longint'(ifc.s_ready), 1);
        check("rst_m_valid", longint'(ifc.m_valid), 0);
        check("rst_m_pow", longint'(ifc.m_pow), 0);
`ifdef IQ_POWER_PEAK_EN
        check("rst_m_peak", longint'(ifc.m_peak), 0);
`endif
        tick();
        rst_n = 1'b1;
        tick();

        // 3-4-5 block and its latency from the last accept
        repeat (4) send(3, 4);
        check("lat_e0", longint'(ifc.m_valid), 0);
        tick();
        check("lat_e1", longint'(ifc.m_valid), 0);
        tick();
        check("lat_e2", longint'(ifc.m_valid), 0);
        tick();
        check("lat_e3", longint'(ifc.m_valid), 1);
        check("pow_345", longint'(ifc.m_pow), 25);
        tick();

        // Full-scale negative corner
        repeat (4) send(-32768, -32768);
        wait_valid("full_scale", 64'd2147483648);
`ifdef IQ_POWER_PEAK_EN
        check("full_scale_peak", longint'(ifc.m_peak), 64'd2147483648);
`endif
        tick();

        // 1+2+4+4 = 11, truncated mean 2
        send(1, 0);
        send(1, 1);
        send(2, 0);
        send(0, -2);
        wait_valid("trunc", 2);
        tick();

        // Mixed signs: (169+625+289+841)/4 = 481
        send(-5, 12);
        send(7, -24);
        send(-8, -15);
        send(20, 21);
        wait_valid("mixed", 481);
`ifdef IQ_POWER_PEAK_EN
        check("mixed_peak", longint'(ifc.m_peak), 841);
`endif
        tick();

        // Backpressure: block of 4s held while the next block streams in (mean 174/4 = 43)
        ifc.m_ready = 1'b0;
        fork
            begin
                repeat (4) send(2, 0);
                send(5, 0);
                send(6, 0);
                send(0, 7);
                send(8, 0);
            end
            begin
                wait_valid("stall_hold", 4);
                check("stall_s_ready", longint'(ifc.s_ready), 0);
                repeat (5) begin
                    @(negedge clk);
                    check("stall_pow_held", longint'(ifc.m_pow), 4);
                    check("stall_s_ready_held", longint'(ifc.s_ready), 0);
                end
                tick();
                ifc.m_ready = 1'b1;
            end
        join
        wait_valid("stall_next", 43);
        tick();

        // Flush a partial block; a sample presented with clr is dropped too
        send(100, 100);
        send(100, 100);
        repeat (4) tick();
        clr         = 1'b1;
        ifc.s_valid = 1'b1;
        ifc.s_i     = IW'(50);
        ifc.s_q     = '0;
        tick();
        clr         = 1'b0;
        ifc.s_valid = 1'b0;
        repeat (4) send(1, 0);
        wait_valid("after_clr", 1);
        tick();

        // Asynchronous reset with a held result and a partial block in flight
        ifc.m_ready = 1'b0;
        repeat (6) send(3, 4);
        wait_valid("pre_reset", 25);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_m_valid", longint'(ifc.m_valid), 0);
        check("arst_m_pow", longint'(ifc.m_pow), 0);
        check("arst_s_ready", longint'(ifc.s_ready), 1);
        tick();
        tick();
        rst_n       = 1'b1;
        ifc.m_ready = 1'b1;
        tick();
        repeat (4) send(7, 0);
        wait_valid("post_reset", 49);
        tick();

        repeat (6) tick();
        check("exp_drained", longint'(exp_pow.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/iq_power_avg.md
# iq_power_avg

Block-averaging power estimator sitting directly upstream of the combinational square-root stage in the magnitude/RMS path. Accepts signed I/Q samples over a valid/ready stream, computes I²+Q² in a short pipeline, and averages it over 2^AVG_LOG2 samples. Emits one unsigned mean-power word per block, sized to feed the square-root input directly, so the downstream result is the block RMS magnitude.

## Interface
- IW, 16: signed width of each I and Q sample.
- AVG_LOG2, 4: log2 of block length; range 0..8.
- OW, 32: output width. Must be even, because it feeds the square-root stage's N.

- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- clr  in  1  synchronous flush of pipeline and partial block.
- s_i  in  IW  signed in-phase sample.
- s_q  in  IW  signed quadrature sample.
- s_valid  in  1  input sample valid.
- s_ready  out  1  block can accept a sample.
- m_pow  out  OW  unsigned mean power of the last completed block.
- m_valid  out  1  m_pow valid.
- m_ready  in  1  downstream accepts m_pow.
- m_peak  out  OW  peak instantaneous I²+Q² in the block. Present only with IQ_POWER_PEAK_EN.

## Operation
- Transfer occurs when s_valid && s_ready. Output transfer occurs when m_valid && m_ready.
- Stall condition: stall = m_valid && !m_ready. s_ready = !stall. While stalled, every pipeline stage, the valid bits and the block counter hold.
- Pipeline stages:
  - S1 registers s_i and s_q.
  - S2 registers i² and q², each 2·IW bits unsigned.
  - S3 registers sq = i²+q² on 2·IW bits. No overflow is possible: the maximum is 2^(2·IW−1), at I=Q=−2^(IW−1).
- Accumulate stage:
  - acc has 2·IW+AVG_LOG2 bits. cnt has AVG_LOG2 bits.
  - On each valid S3 word: if cnt==0, acc←sq; else acc←acc+sq. Then cnt←cnt+1, wrapping modulo 2^AVG_LOG2.
  - When a valid S3 word arrives with cnt==2^AVG_LOG2−1, the block closes:
    - mean = (acc+sq) >> AVG_LOG2, truncating.
    - m_pow ← mean, saturated to 2^OW−1 if OW < 2·IW, zero-extended otherwise.
    - m_valid ← 1.
- m_valid clears on output transfer unless a new block closes in the same cycle.
- Bubbles (s_valid low) propagate as invalid stages. They do not advance cnt.
- clr:
  - Clears all stage valid bits, cnt and acc.
  - Does not clear m_valid or m_pow: a finished result is never dropped.
  - A sample presented with clr is discarded.
- AVG_LOG2=0: every sample closes a block, and m_pow=sq.
- Reset values: s_ready=1, m_valid=0, m_pow=0, m_peak=0, cnt=0, acc=0, all stage valids 0.

## Timing
- Latency: the last sample of a block accepted at edge E gives m_valid=1 after edge E+3, with no stall.
- Throughput: one sample per clock while m_ready stays high, or while blocks are spaced ≥1 cycle apart from the output.
- Stall response is combinational: s_ready drops in the same cycle m_valid && !m_ready holds.
- Asynchronous reset mid-block: all state returns to reset values immediately. The first block after release starts at cnt=0.

## Configuration
- IQ_POWER_PEAK_EN defined:
  - A peak register tracks max(sq) over the block and resets with cnt==0 loads.
  - m_peak is loaded alongside m_pow, with the same saturation rule.
  - clr and rst_n zero the peak register.
- IQ_POWER_PEAK_EN undefined: m_peak port and peak logic are absent. Behaviour is otherwise identical.

## Structure
- Package iq_power_pkg:
  - Width helper constants: SQ_W=2·IW and ACC_W=SQ_W+AVG_LOG2 defaults.
  - Saturating-resize function.
  - Stage-valid bundle typedef.
- Sub-module iq_mag_sq: pipelines S1–S3 and propagates valid with a stall enable. It is reusable by other magnitude paths.
- Top level: accumulator, counter, output register, peak option, handshake.

## Test plan
- IW=16, AVG_LOG2=2, OW=32:
  - Stimulus: 4 samples of I=3, Q=4 streamed back-to-back.
  - Required: m_pow=25, m_valid rises 3 cycles after the 4th accept.
- Stimulus: 4 samples of I=Q=−32768.
  - Required: m_pow=2147483648, no wrap.
  - With peak enabled: m_peak=2147483648.
- Stimulus: samples sq=1,2,3,5.
  - Required: m_pow=2, from truncation of 11/4.
- Stimulus: hold m_ready=0 with a completed block while streaming.
  - Required: s_ready=0 the same cycle, and no sample lost.
  - Release m_ready: the next block completes with correct values.
- Stimulus: 2 samples of a block, then pulse clr, then 4 samples of I=1, Q=0.
  - Required: m_pow=1, with no contribution from the pre-clr samples.
- Stimulus: assert rst_n low mid-block while m_valid=1.
  - Required: m_valid=0 and m_pow=0 immediately.
  - A fresh 4-sample block after release gives the correct mean.
